// File: rtl/matrix_feeder_pkg.sv
// Shared definitions for the matrix feeder: FSM encoding and data/index widths.
package matrix_feeder_pkg;

    localparam int FLOAT_W = 32;
    localparam int IDX_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SEND     = 2'd1,
        ST_WAIT_ROW = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    // Width of a counter that indexes n entries (never narrower than one bit).
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/matrix_feeder_handshake_source.sv
// Single strobe/ack source: captures a word on load and holds it, with the
// strobe raised, until the consumer acknowledges it.
module handshake_source
    import matrix_feeder_pkg::*;
#(
    parameter int W = FLOAT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         ack_i,
    output logic         stb_o,
    output logic [W-1:0] data_o
);

    logic         stb_q;
    logic [W-1:0] data_q;

    // Load raises the strobe; an ack is only honoured while the strobe is up.
    always_ff @(posedge clk) begin
        if (rst) begin
            stb_q  <= 1'b0;
            data_q <= '0;
        end else if (load_i) begin
            stb_q  <= 1'b1;
            data_q <= data_i;
        end else if (stb_q && ack_i) begin
            stb_q  <= 1'b0;
        end
    end

    assign stb_o  = stb_q;
    assign data_o = data_q;

endmodule

// File: rtl/matrix_feeder.sv
// Feeds A elements and B rows to an external multiplier pair by pair, collects
// the returned result rows and offers them for registered readback.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | storage writable, waiting for start
// ST_SEND     | pair (A[i][k], B[k]) on both channels until both are acked
// ST_WAIT_ROW | all pairs of row i sent, waiting for the result row
// ST_DONE     | one-cycle done pulse, then back to idle
module matrix_feeder
    import matrix_feeder_pkg::*;
#(
    parameter int ROWS_A = 2,
    parameter int COLS_A = 2,
    parameter int COLS_B = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic                      wr_sel,
    input  logic [IDX_W-1:0]          wr_r,
    input  logic [IDX_W-1:0]          wr_c,
    input  logic [FLOAT_W-1:0]        wr_data,
    input  logic                      start,
    output logic [FLOAT_W-1:0]        input_cell,
    output logic                      input_cell_stb,
    input  logic                      input_cell_ack,
    output logic [FLOAT_W*COLS_B-1:0] input_row,
    output logic                      input_row_stb,
    input  logic                      input_row_ack,
    input  logic [FLOAT_W*COLS_B-1:0] output_row,
    input  logic                      output_row_stb,
    input  logic [IDX_W-1:0]          rd_addr,
    output logic [FLOAT_W*COLS_B-1:0] rd_row,
    output logic                      busy,
    output logic                      done,
    output logic                      proto_err
);

    localparam int ROW_W = FLOAT_W * COLS_B;
    localparam int IW    = idx_bits(ROWS_A);
    localparam int KW    = idx_bits(COLS_A);
    localparam logic [IW-1:0] I_LAST = IW'(ROWS_A - 1);
    localparam logic [KW-1:0] K_LAST = KW'(COLS_A - 1);

    // Storage is deliberately not reset so a reset between runs keeps A, B and results.
    logic [FLOAT_W-1:0] mem_a  [ROWS_A][COLS_A];
    logic [ROW_W-1:0]   mem_b  [COLS_A];
    logic [ROW_W-1:0]   result [ROWS_A];

    state_t          state_q, state_d;
    logic [IW-1:0]   i_q, i_d;
    logic [KW-1:0]   k_q, k_d;
    logic            launch;
    logic            proto_err_q;
    logic [ROW_W-1:0] rd_row_q, rd_row_d;

    // FSM state and row/pair counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            i_q     <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            k_q     <= k_d;
        end
    end

    // Next state; launch loads both channels so strobes rise on entering a pair.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        k_d     = k_q;
        launch  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    i_d     = '0;
                    k_d     = '0;
                    launch  = 1'b1;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (!input_cell_stb && !input_row_stb) begin
                    if (k_q != K_LAST) begin
                        k_d    = k_q + 1'b1;
                        launch = 1'b1;
                    end else begin
                        state_d = ST_WAIT_ROW;
                    end
                end
            end
            ST_WAIT_ROW: begin
                if (output_row_stb) begin
                    if (i_q != I_LAST) begin
                        i_d     = i_q + 1'b1;
                        k_d     = '0;
                        launch  = 1'b1;
                        state_d = ST_SEND;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    handshake_source #(.W(FLOAT_W)) u_cell_src (
        .clk    (clk),
        .rst    (rst),
        .load_i (launch),
        .data_i (mem_a[i_d][k_d]),
        .ack_i  (input_cell_ack),
        .stb_o  (input_cell_stb),
        .data_o (input_cell)
    );

    handshake_source #(.W(ROW_W)) u_row_src (
        .clk    (clk),
        .rst    (rst),
        .load_i (launch),
        .data_i (mem_b[k_d]),
        .ack_i  (input_row_ack),
        .stb_o  (input_row_stb),
        .data_o (input_row)
    );

    // Element writes in idle only (out-of-range indices match nothing) and result capture.
    always_ff @(posedge clk) begin
        if (wr_en && state_q == ST_IDLE) begin
            for (int r = 0; r < ROWS_A; r++) begin
                for (int c = 0; c < COLS_A; c++) begin
                    if (!wr_sel && wr_r == IDX_W'(r) && wr_c == IDX_W'(c))
                        mem_a[r][c] <= wr_data;
                end
            end
            for (int r = 0; r < COLS_A; r++) begin
                for (int c = 0; c < COLS_B; c++) begin
                    if (wr_sel && wr_r == IDX_W'(r) && wr_c == IDX_W'(c))
                        mem_b[r][c*FLOAT_W +: FLOAT_W] <= wr_data;
                end
            end
        end
        if (state_q == ST_WAIT_ROW && output_row_stb)
            result[i_q] <= output_row;
    end

    // Readback mux; addresses beyond the result rows read as zero.
    always_comb begin
        rd_row_d = '0;
        for (int r = 0; r < ROWS_A; r++) begin
            if (rd_addr == IDX_W'(r))
                rd_row_d = result[r];
        end
    end

    // Registered readback and sticky protocol error for stray result pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_row_q    <= '0;
            proto_err_q <= 1'b0;
        end else begin
            rd_row_q <= rd_row_d;
            if (output_row_stb && state_q != ST_WAIT_ROW)
                proto_err_q <= 1'b1;
        end
    end

    assign rd_row    = rd_row_q;
    assign proto_err = proto_err_q;
    assign busy      = (state_q == ST_SEND) || (state_q == ST_WAIT_ROW);
    assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_matrix_feeder.sv
// Self-checking bench for matrix_feeder: responder stub with configurable ack
// delays, pair/row sequence model, readback table and multi-cycle corner cases.
module tb_matrix_feeder;

    localparam int RA = 2;
    localparam int CA = 2;
    localparam int CB = 2;
    localparam int RW = 32 * CB;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en, wr_sel;
    logic [7:0]    wr_r, wr_c;
    logic [31:0]   wr_data;
    logic          start;
    logic [31:0]   input_cell;
    logic          input_cell_stb, input_cell_ack;
    logic [RW-1:0] input_row;
    logic          input_row_stb, input_row_ack;
    logic [RW-1:0] output_row;
    logic          output_row_stb;
    logic [7:0]    rd_addr;
    logic [RW-1:0] rd_row;
    logic          busy, done, proto_err;

    always #5 clk = ~clk;

    matrix_feeder #(.ROWS_A(RA), .COLS_A(CA), .COLS_B(CB)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_r(wr_r), .wr_c(wr_c),
        .wr_data(wr_data), .start(start),
        .input_cell(input_cell), .input_cell_stb(input_cell_stb), .input_cell_ack(input_cell_ack),
        .input_row(input_row), .input_row_stb(input_row_stb), .input_row_ack(input_row_ack),
        .output_row(output_row), .output_row_stb(output_row_stb),
        .rd_addr(rd_addr), .rd_row(rd_row), .busy(busy), .done(done), .proto_err(proto_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [RW:0] act, input logic [RW:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: matrices as plain arrays, result rows as the stub returns them.
    logic [31:0]   a_m   [RA][CA];
    logic [31:0]   b_m   [CA][CB];
    logic [RW-1:0] ret_m [RA];

    function automatic logic [RW-1:0] b_row(input int k);
        logic [RW-1:0] v;
        for (int j = 0; j < CB; j++) v[32*j +: 32] = b_m[k][j];
        return v;
    endfunction

    // Responder / monitor state.
    int  cell_dly = 0, row_dly = 0, extra_max = 0;
    bit  noise = 0;
    int  cell_cnt, row_cnt, cells_in_row, rows_in_row, pend, ret_idx, done_cnt;
    bit  stub_raised, prev_cell_stb, prev_row_stb, cell_hold, row_hold;
    logic [31:0]   prev_cell;
    logic [RW-1:0] prev_row;
    logic [31:0]   got_cell[$];
    logic [RW-1:0] got_row[$];
    int            cell_len[$], row_len[$];

    task automatic stub_reset();
        cell_cnt = 0; row_cnt = 0; cells_in_row = 0; rows_in_row = 0;
        pend = -1; ret_idx = 0; cell_hold = 0; row_hold = 0;
        prev_cell_stb = 0; prev_row_stb = 0;
        input_cell_ack = 0; input_row_ack = 0;
        if (stub_raised) begin output_row_stb = 0; stub_raised = 0; end
    endtask

    initial begin
        stub_raised = 0;
        done_cnt = 0;
        stub_reset();
        forever begin
            @(negedge clk);
            if (rst) begin
                stub_reset();
            end else begin
                if (stub_raised) begin output_row_stb = 0; stub_raised = 0; end
                if (pend > 0) pend--;
                if (pend == 0) begin
                    output_row = ret_m[ret_idx];
                    output_row_stb = 1;
                    stub_raised = 1;
                    pend = -1;
                    ret_idx = (ret_idx + 1) % RA;
                end
                if (done) done_cnt++;
                if (cell_hold) begin
                    check("cell_stb_hold", input_cell_stb, 1);
                    check("cell_data_hold", input_cell, prev_cell);
                end
                if (row_hold) begin
                    check("row_stb_hold", input_row_stb, 1);
                    check("row_data_hold", input_row, prev_row);
                end
                if ((input_cell_stb && !prev_cell_stb) || (input_row_stb && !prev_row_stb))
                    check("pair_launch", {input_cell_stb && !prev_cell_stb, input_row_stb && !prev_row_stb}, 2'b11);
                input_cell_ack = input_cell_stb ? (cell_cnt + 1 >= cell_dly) : (noise && $urandom_range(0, 1) == 1);
                input_row_ack  = input_row_stb  ? (row_cnt + 1 >= row_dly)   : (noise && $urandom_range(0, 1) == 1);
                cell_hold = 0;
                row_hold  = 0;
                if (input_cell_stb && input_cell_ack) begin
                    got_cell.push_back(input_cell);
                    cell_len.push_back(cell_cnt + 1);
                    cell_cnt = 0;
                    cells_in_row++;
                end else if (input_cell_stb) begin
                    cell_cnt++;
                    cell_hold = 1;
                end else cell_cnt = 0;
                if (input_row_stb && input_row_ack) begin
                    got_row.push_back(input_row);
                    row_len.push_back(row_cnt + 1);
                    row_cnt = 0;
                    rows_in_row++;
                end else if (input_row_stb) begin
                    row_cnt++;
                    row_hold = 1;
                end else row_cnt = 0;
                prev_cell = input_cell;     prev_row = input_row;
                prev_cell_stb = input_cell_stb; prev_row_stb = input_row_stb;
                if (cells_in_row == CA && rows_in_row == CA && pend < 0) begin
                    pend = 2 + $urandom_range(0, extra_max);
                    cells_in_row = 0;
                    rows_in_row = 0;
                end
            end
        end
    end

    task automatic wr(input bit sel, input int r, input int c, input logic [31:0] d);
        @(negedge clk);
        wr_en = 1; wr_sel = sel; wr_r = 8'(r); wr_c = 8'(c); wr_data = d;
        @(negedge clk);
        wr_en = 0;
    endtask

    task automatic load_all();
        for (int r = 0; r < RA; r++) for (int c = 0; c < CA; c++) wr(0, r, c, a_m[r][c]);
        for (int r = 0; r < CA; r++) for (int c = 0; c < CB; c++) wr(1, r, c, b_m[r][c]);
    endtask

    task automatic start_run();
        got_cell.delete(); got_row.delete(); cell_len.delete(); row_len.delete();
        done_cnt = 0;
        ret_idx = 0;
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
    endtask

    task automatic wait_done(input string name);
        int cyc = 0;
        while (done_cnt == 0 && cyc < 400) begin @(negedge clk); cyc++; end
        if (done_cnt == 0) check({name, "_timeout"}, 0, 1);
        repeat (4) @(negedge clk);
        check({name, "_done_count"}, done_cnt, 1);
        check({name, "_busy_idle"}, busy, 0);
    endtask

    task automatic check_run(input string name, input bit exp_perr);
        int idx = 0;
        int ec = (cell_dly < 1) ? 1 : cell_dly;
        int er = (row_dly < 1) ? 1 : row_dly;
        check({name, "_cell_count"}, got_cell.size(), RA * CA);
        check({name, "_row_count"}, got_row.size(), RA * CA);
        for (int i = 0; i < RA; i++) begin
            for (int k = 0; k < CA; k++) begin
                check({name, "_cell"}, (idx < got_cell.size()) ? got_cell[idx] : 'x, a_m[i][k]);
                check({name, "_row"}, (idx < got_row.size()) ? got_row[idx] : 'x, b_row(k));
                check({name, "_cell_len"}, (idx < cell_len.size()) ? cell_len[idx] : -1, ec);
                check({name, "_row_len"}, (idx < row_len.size()) ? row_len[idx] : -1, er);
                idx++;
            end
        end
        check({name, "_proto_err"}, proto_err, exp_perr);
    endtask

    task automatic read_rows(input string name);
        for (int r = 0; r < RA; r++) begin
            @(negedge clk); rd_addr = 8'(r);
            @(negedge clk); check({name, "_rd"}, rd_row, ret_m[r]);
        end
        @(negedge clk); rd_addr = 8'($urandom_range(RA, 255));
        @(negedge clk); check({name, "_rd_oob"}, rd_row, 0);
    endtask

    typedef struct {
        logic [7:0]    addr;
        logic [RW-1:0] exp;
    } rd_vec_t;

    rd_vec_t rd_tab[4];

    initial begin
        int cyc;
        rd_tab[0].addr = 8'd0;   rd_tab[0].exp = {32'h40400000, 32'h40000000};
        rd_tab[1].addr = 8'd1;   rd_tab[1].exp = {32'h40A00000, 32'h40800000};
        rd_tab[2].addr = 8'd5;   rd_tab[2].exp = '0;
        rd_tab[3].addr = 8'd255; rd_tab[3].exp = '0;

        rst = 1; wr_en = 0; wr_sel = 0; wr_r = 0; wr_c = 0; wr_data = 0; start = 0;
        output_row = 0; output_row_stb = 0; rd_addr = 0;
        repeat (3) @(negedge clk);
        check("rst_cell_stb", input_cell_stb, 0);
        check("rst_row_stb", input_row_stb, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_proto_err", proto_err, 0);
        check("rst_rd_row", rd_row, 0);
        check("rst_input_cell", input_cell, 0);
        check("rst_input_row", input_row, 0);
        rst = 0;

        // Identity A, B = [[2,3],[4,5]]; stub returns I x B = B.
        a_m[0][0] = 32'h3F800000; a_m[0][1] = 32'h0; a_m[1][0] = 32'h0; a_m[1][1] = 32'h3F800000;
        b_m[0][0] = 32'h40000000; b_m[0][1] = 32'h40400000;
        b_m[1][0] = 32'h40800000; b_m[1][1] = 32'h40A00000;
        ret_m[0] = b_row(0); ret_m[1] = b_row(1);
        load_all();
        wr(0, 2, 0, 32'hBAD0BAD0);
        wr(0, 0, 5, 32'hBAD1BAD1);
        wr(1, 3, 1, 32'hBAD2BAD2);

        cell_dly = 0; row_dly = 0;
        start_run(); wait_done("zero_dly"); check_run("zero_dly", 0);
        for (int t = 0; t < 4; t++) begin
            @(negedge clk); rd_addr = rd_tab[t].addr;
            @(negedge clk); check("rd_table", rd_row, rd_tab[t].exp);
        end
        @(negedge clk); rd_addr = 8'd0;
        @(negedge clk); rd_addr = 8'd1;
        #1 check("rd_latency", rd_row, rd_tab[0].exp);

        cell_dly = 3; row_dly = 1;
        start_run(); wait_done("dly_3_1"); check_run("dly_3_1", 0);

        // Start and A write while busy must be ignored.
        cell_dly = 2; row_dly = 2;
        start_run();
        repeat (2) @(negedge clk);
        check("inject_busy", busy, 1);
        start = 1; wr_en = 1; wr_sel = 0; wr_r = 0; wr_c = 0; wr_data = 32'hDEADBEEF;
        @(negedge clk); start = 0; wr_en = 0;
        wait_done("busy_inj"); check_run("busy_inj", 0);
        cell_dly = 0; row_dly = 0;
        start_run(); wait_done("after_inj"); check_run("after_inj", 0);

        // Reset during the second pair.
        cell_dly = 3; row_dly = 3;
        start_run();
        cyc = 0;
        while (!(got_cell.size() >= 1 && input_cell_stb) && cyc < 100) begin @(negedge clk); cyc++; end
        check("mid_rst_reached", got_cell.size() >= 1 && input_cell_stb, 1);
        @(posedge clk); #2 rst = 1;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_cell_stb", input_cell_stb, 0);
        check("mid_rst_row_stb", input_row_stb, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        rst = 0;
        repeat (6) @(negedge clk);
        check("mid_rst_no_done", done_cnt, 0);
        start_run(); wait_done("rerun"); check_run("rerun", 0);
        read_rows("rerun");

        // Randomised products with random ack delays and ack noise while strobes are low.
        noise = 1; extra_max = 2;
        for (int n = 0; n < 12; n++) begin
            for (int r = 0; r < RA; r++) for (int c = 0; c < CA; c++) a_m[r][c] = $urandom;
            for (int r = 0; r < CA; r++) for (int c = 0; c < CB; c++) b_m[r][c] = $urandom;
            for (int r = 0; r < RA; r++) ret_m[r] = {$urandom, $urandom};
            cell_dly = $urandom_range(0, 3); row_dly = $urandom_range(0, 3);
            load_all();
            start_run(); wait_done("rand"); check_run("rand", 0);
            read_rows("rand");
        end
        noise = 0; extra_max = 0;

        // Stray result pulse in idle: sticky error, storage untouched.
        @(negedge clk); output_row = {$urandom, $urandom}; output_row_stb = 1;
        @(negedge clk); output_row_stb = 0;
        check("perr_set", proto_err, 1);
        read_rows("perr");
        repeat (10) @(negedge clk);
        check("perr_sticky", proto_err, 1);
        cell_dly = 1; row_dly = 0;
        start_run(); wait_done("perr_run"); check_run("perr_run", 1);
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0;
        check("perr_cleared", proto_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/matrix_feeder.md
MATRIX_FEEDER -- requirements
Module: matrix_feeder

Interface
REQ-001 The block SHALL have parameter ROWS_A, default 2, meaning rows of matrix A and number of result rows.
REQ-002 The block SHALL have parameter COLS_A, default 2, meaning columns of A, which equals rows of B.
REQ-003 The block SHALL have parameter COLS_B, default 2, meaning columns of B and elements per streamed row.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port wr_en, input, 1 bit: load strobe for one 32-bit element.
REQ-007 The block SHALL have port wr_sel, input, 1 bit: target matrix, 0 = A, 1 = B.
REQ-008 The block SHALL have ports wr_r and wr_c, input, 8 bits each: row and column index of the element.
REQ-009 The block SHALL have port wr_data, input, 32 bits: IEEE-754 single element.
REQ-010 The block SHALL have port start, input, 1 bit: begin the product A x B.
REQ-011 The block SHALL have ports input_cell (output, 32 bits), input_cell_stb (output, 1 bit) and input_cell_ack (input, 1 bit): the A-element channel to the multiplier.
REQ-012 The block SHALL have ports input_row (output, 32*COLS_B bits; element j at bits [32j +: 32]), input_row_stb (output, 1 bit) and input_row_ack (input, 1 bit): the B-row channel.
REQ-013 The block SHALL have ports output_row (input, 32*COLS_B bits) and output_row_stb (input, 1 bit): a result-row pulse from the multiplier.
REQ-014 The block SHALL have ports rd_addr (input, 8 bits) and rd_row (output, 32*COLS_B bits): result readback.
REQ-015 The block SHALL have outputs busy (1 bit), done (1 bit, one-cycle pulse) and proto_err (1 bit, sticky).

Function
REQ-016 The block SHALL write wr_data to A[wr_r][wr_c] or B[wr_r][wr_c] on a cycle with wr_en high while in IDLE; out-of-range indices and writes outside IDLE SHALL be ignored.
REQ-017 The FSM SHALL have states IDLE, SEND, WAIT_ROW and DONE; busy SHALL be high in SEND and WAIT_ROW.
REQ-018 A start seen in IDLE SHALL clear counters i (row) and k (pair) and enter SEND on the next edge; start in any other state SHALL be ignored.
REQ-019 On entry to SEND, the block SHALL drive input_cell = A[i][k] and input_row = B[k], and raise both strobes in the same cycle.
REQ-020 Each strobe SHALL remain high with its data stable until its ack is sampled high, then fall on the next edge; the two channels SHALL complete independently.
REQ-021 When both channels have completed for pair k, then if k < COLS_A-1 the block SHALL increment k and raise both strobes again on the next cycle; otherwise it SHALL enter WAIT_ROW.
REQ-022 An ack arriving while its strobe is low SHALL be ignored.
REQ-023 In WAIT_ROW, output_row_stb SHALL store output_row into result[i]; then, if i < ROWS_A-1, the block SHALL increment i, clear k and return to SEND; otherwise it SHALL enter DONE.
REQ-024 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-025 output_row_stb seen in any state other than WAIT_ROW SHALL be discarded and SHALL set proto_err; proto_err SHALL clear only on reset.
REQ-026 rd_row SHALL equal result[rd_addr] registered, with one-cycle latency; rd_addr >= ROWS_A SHALL return 0.
REQ-027 The block SHALL perform no arithmetic on the data; it only moves data.

Reset
REQ-028 Reset SHALL drive FSM = IDLE; i = k = 0; strobes, busy, done, proto_err and rd_row = 0; input_cell and input_row = 0.
REQ-029 Reset mid-operation SHALL drop both strobes at that edge and abandon the transfer, with no done pulse.
REQ-030 Reset SHALL NOT clear the A, B or result storage.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding, the float width constant (32) and the index width (8).
REQ-032 One sub-module, handshake_source (a single stb/ack channel holding data until ack), SHALL be instantiated twice, once per channel.

Verification
REQ-033 The bench SHALL load A=I (0x3F800000 on the diagonal, 0 elsewhere) and B=[[2,3],[4,5]] (0x40000000, 0x40400000, 0x40800000, 0x40A00000), and use a responder stub that acks after 0 cycles; the channels SHALL carry the pair sequence (A00,B0), (A01,B1), (A10,B0), (A11,B1), and done SHALL pulse once.
REQ-034 With cell ack delayed 3 cycles and row ack delayed 1 cycle, input_row_stb SHALL fall after 1 cycle, input_cell_stb SHALL hold for 3 cycles with data stable, and the next pair SHALL start only after both complete.
REQ-035 The stub SHALL return rows 0x40000000/0x40400000 and 0x40800000/0x40A00000; rd_addr 0 and 1 SHALL read those rows one cycle later, and rd_addr 5 SHALL read 0.
REQ-036 An output_row_stb pulse in IDLE SHALL set proto_err and leave result unchanged; proto_err SHALL stay high until rst.
REQ-037 rst asserted during the second pair SHALL give strobes 0, busy 0 and no done on the next cycle; a new start SHALL rerun the product correctly from the preserved A and B.
REQ-038 A start or wr_en while busy SHALL be ignored, and A[0][0] SHALL be unchanged afterwards.
